// File: rtl/pipe_scroller_if.sv
// Interface bundling the pipe_scroller control inputs and its position/score outputs.
// master: the round controller that drives Start/Lose/Ack and observes the pipe.
// slave:  the pipe_scroller itself.
interface pipe_scroller_if;
    logic       Start;
    logic       Lose;
    logic       Ack;
    logic [9:0] X_Edge;
    logic [9:0] Y_Edge;
    logic [7:0] Score;
    logic       Score_Pulse;
    logic       Step;
    logic       Q_Idle;
    logic       Q_Scroll;
    logic       Q_Frozen;

    modport master (
        output Start, Lose, Ack,
        input  X_Edge, Y_Edge, Score, Score_Pulse, Step, Q_Idle, Q_Scroll, Q_Frozen
    );

    modport slave (
        input  Start, Lose, Ack,
        output X_Edge, Y_Edge, Score, Score_Pulse, Step, Q_Idle, Q_Scroll, Q_Frozen
    );
endinterface

// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls a pipe leftwards one step per tick, wraps it to the
// right edge with a pseudo-random gap from a 16-bit LFSR, and counts pipes
// that pass the bird column. Freezes on Lose, returns to idle on Ack.
// Optional feature macro: SCROLL_SPEEDUP_EN (step size grows every 8 points).
module pipe_scroller #(
    parameter int unsigned SCREEN_RIGHT = 640,
    parameter int unsigned PIPE_WIDTH   = 52,
    parameter int unsigned BIRD_X       = 320,
    parameter int unsigned TICK_DIV     = 250000,
    parameter int unsigned GAP_MIN      = 80,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic              Clk,
    input  logic              reset,
    pipe_scroller_if.slave    bus
);
    localparam int unsigned CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [9:0]    x, x_n;
    logic [9:0]    y, y_n;
    logic [15:0]   lfsr, lfsr_n;
    logic [7:0]    score, score_n;
    logic          step, step_n;
    logic          pulse, pulse_n;
    logic [2:0]    q_flags;

    logic [2:0]    speed;
    logic [15:0]   lfsr_adv;
    logic [9:0]    x_dec;
    logic [10:0]   trail_old, trail_new;
    logic          wrap, crossing, tc;

`ifdef SCROLL_SPEEDUP_EN
    // Step size from the current score: 1 + min(Score[7:3], 3).
    always_comb begin
        if (score[7:3] > 5'd3) speed = 3'd4;
        else                   speed = 3'd1 + score[5:3];
    end
`else
    assign speed = 3'd1;
`endif

    assign tc        = (cnt == CW'(TICK_DIV - 1));
    assign wrap      = (x < {7'b0, speed});
    assign x_dec     = x - {7'b0, speed};
    assign lfsr_adv  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign trail_old = {1'b0, x}     + 11'(PIPE_WIDTH);
    assign trail_new = {1'b0, x_dec} + 11'(PIPE_WIDTH);
    assign crossing  = (trail_old > 11'(BIRD_X)) && (trail_new <= 11'(BIRD_X));

    // Next-state and next-output computation for the scroll FSM.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        x_n     = x;
        y_n     = y;
        lfsr_n  = lfsr;
        score_n = score;
        step_n  = 1'b0;
        pulse_n = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (bus.Start) state_n = ST_SCROLL;
            end
            ST_SCROLL: begin
                // Lose takes priority over a coinciding terminal count.
                if (bus.Lose) begin
                    state_n = ST_FROZEN;
                end else if (tc) begin
                    cnt_n  = '0;
                    step_n = 1'b1;
                    if (wrap) begin
                        x_n    = 10'(SCREEN_RIGHT);
                        lfsr_n = lfsr_adv;
                        y_n    = 10'(GAP_MIN) + {2'b0, lfsr_adv[7:0]};
                    end else begin
                        x_n = x_dec;
                        if (crossing && score != 8'hFF) begin
                            score_n = score + 8'd1;
                            pulse_n = 1'b1;
                        end
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_FROZEN: begin
                if (bus.Ack) begin
                    state_n = ST_IDLE;
                    x_n     = 10'(SCREEN_RIGHT);
                    score_n = '0;
                    cnt_n   = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            x       <= 10'(SCREEN_RIGHT);
            lfsr    <= LFSR_SEED;
            y       <= 10'(GAP_MIN) + {2'b0, LFSR_SEED[7:0]};
            score   <= '0;
            step    <= 1'b0;
            pulse   <= 1'b0;
            q_flags <= 3'b001;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            x       <= x_n;
            lfsr    <= lfsr_n;
            y       <= y_n;
            score   <= score_n;
            step    <= step_n;
            pulse   <= pulse_n;
            q_flags <= {state_n == ST_FROZEN, state_n == ST_SCROLL, state_n == ST_IDLE};
        end
    end

    assign bus.X_Edge      = x;
    assign bus.Y_Edge      = y;
    assign bus.Score       = score;
    assign bus.Score_Pulse = pulse;
    assign bus.Step        = step;
    assign bus.Q_Idle      = q_flags[0];
    assign bus.Q_Scroll    = q_flags[1];
    assign bus.Q_Frozen    = q_flags[2];
endmodule

// File: tb/tb_pipe_scroller.sv
// Directed testbench for pipe_scroller with TICK_DIV=4.
module tb_pipe_scroller;
    logic Clk = 1'b0;
    logic reset;

    pipe_scroller_if bus();

    pipe_scroller #(.TICK_DIV(4)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    always #5 Clk = ~Clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input int unsigned actual, input int unsigned expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic wait_step(output int unsigned n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.Step && n < 200);
        if (!bus.Step) check_eq("step_timeout", 0, 1);
    endtask

    task automatic wait_x(input int unsigned target, input int unsigned budget);
        int unsigned n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!(bus.Step && bus.X_Edge == 10'(target)) && n < budget);
        if (!(bus.Step && bus.X_Edge == 10'(target))) check_eq("reach_x_timeout", bus.X_Edge, target);
    endtask

    // Hard stop if something wedges the whole run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "watchdog");
    end

    // Directed stimulus sequence.
    initial begin
        int unsigned n;
        int unsigned pulses;
        int unsigned x0;
        reset = 1'b1;
        bus.Start = 1'b0;
        bus.Lose  = 1'b0;
        bus.Ack   = 1'b0;
        repeat (3) cyc();
        check_eq("rst_idle",   bus.Q_Idle, 1);
        check_eq("rst_x",      bus.X_Edge, 640);
        check_eq("rst_y",      bus.Y_Edge, 305);
        check_eq("rst_score",  bus.Score, 0);
        check_eq("rst_step",   bus.Step, 0);
        check_eq("rst_pulse",  bus.Score_Pulse, 0);
        reset = 1'b0;
        cyc();

        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        check_eq("start_scroll", bus.Q_Scroll, 1);
        check_eq("start_idle",   bus.Q_Idle, 0);

        wait_step(n);
        check_eq("first_step_latency", n, 4);
        check_eq("step1_x", bus.X_Edge, 639);
        cyc();
        check_eq("step_one_cycle", bus.Step, 0);
        wait_step(n);
        check_eq("step_period", n + 1, 4);
        check_eq("step2_x", bus.X_Edge, 638);

        bus.Ack = 1'b1;
        cyc();
        bus.Ack = 1'b0;
        check_eq("ack_ignored_scroll", bus.Q_Scroll, 1);

        wait_x(269, 2000);
        check_eq("pre_cross_score", bus.Score, 0);
        wait_step(n);
        check_eq("cross_x",     bus.X_Edge, 268);
        check_eq("cross_score", bus.Score, 1);
        check_eq("cross_pulse", bus.Score_Pulse, 1);
        cyc();
        check_eq("pulse_one_cycle", bus.Score_Pulse, 0);
        wait_step(n);
        check_eq("post_cross_x",     bus.X_Edge, 267);
        check_eq("post_cross_pulse", bus.Score_Pulse, 0);
        check_eq("post_cross_score", bus.Score, 1);

        wait_x(0, 2000);
        wait_step(n);
        check_eq("wrap_x",     bus.X_Edge, 640);
        check_eq("wrap_y",     bus.Y_Edge, 275);
        check_eq("wrap_score", bus.Score, 1);
        check_eq("wrap_pulse", bus.Score_Pulse, 0);

        // Counter is 0 here; three edges bring it to terminal count.
        repeat (3) cyc();
        bus.Lose = 1'b1;
        cyc();
        check_eq("lose_no_step", bus.Step, 0);
        check_eq("lose_x",       bus.X_Edge, 640);
        check_eq("lose_frozen",  bus.Q_Frozen, 1);
        check_eq("lose_score",   bus.Score, 1);
        bus.Lose = 1'b0;
        repeat (6) cyc();
        check_eq("frozen_hold_x", bus.X_Edge, 640);
        check_eq("frozen_hold_state", bus.Q_Frozen, 1);
        bus.Ack = 1'b1;
        cyc();
        bus.Ack = 1'b0;
        check_eq("ack_idle",  bus.Q_Idle, 1);
        check_eq("ack_x",     bus.X_Edge, 640);
        check_eq("ack_score", bus.Score, 0);
        check_eq("ack_y",     bus.Y_Edge, 275);

        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        pulses = 0;
        n = 0;
        do begin
            cyc();
            n++;
            if (bus.Score_Pulse) pulses++;
        end while (bus.Score != 8'd5 && n < 16000);
        check_eq("run_score5", bus.Score, 5);
        check_eq("run_pulses", pulses, 5);
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_eq("midrst_idle",  bus.Q_Idle, 1);
        check_eq("midrst_x",     bus.X_Edge, 640);
        check_eq("midrst_score", bus.Score, 0);
        check_eq("midrst_y",     bus.Y_Edge, 305);

`ifdef SCROLL_SPEEDUP_EN
        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.Score != 8'd8 && n < 25000);
        check_eq("run_score8", bus.Score, 8);
        wait_step(n);
        x0 = bus.X_Edge;
        wait_step(n);
        if (x0 >= 2) check_eq("speed2_drop", x0 - bus.X_Edge, 2);
        else         check_eq("speed2_wrap", bus.X_Edge, 640);
`else
        x0 = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
